// File: rtl/video_timing_gen_if.sv
// Bundles the video timing generator's mode controls and its timing/pixel outputs.
// The generator side uses the master modport; the video sink uses slave.
interface video_timing_gen_if;
  logic       pal;
  logic       scandouble;
  logic [1:0] pattern;
  logic       ce_pix;
  logic       HBlank;
  logic       VBlank;
  logic       HSync;
  logic       VSync;
  logic       frame_start;
  logic [9:0] x;
  logic [9:0] y;
  logic [15:0] frame;
  logic [7:0] video;

  modport master (
    input  pal, scandouble, pattern,
    output ce_pix, HBlank, VBlank, HSync, VSync, frame_start, x, y, frame, video
  );

  modport slave (
    output pal, scandouble, pattern,
    input  ce_pix, HBlank, VBlank, HSync, VSync, frame_start, x, y, frame, video
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing source: pixel enable, H/V counters, blank/sync and an
// 8-bit test pattern, with NTSC/PAL height and scandoubling chosen per frame.
module video_timing_gen #(
  parameter int CE_DIV       = 8,
  parameter int H_ACTIVE     = 320,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 32,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 240,
  parameter int V_FP         = 4,
  parameter int V_SYNC       = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input logic clk,
  input logic reset_n,
  video_timing_gen_if.master vid
);

  typedef enum logic [1:0] {
    PAT_NOISE    = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_SCROLL   = 2'd3
  } pattern_e;

  localparam int         H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VT_NTSC    = 10'(V_TOTAL_NTSC);
  localparam logic [9:0] VT_PAL     = 10'(V_TOTAL_PAL);
  localparam logic [7:0] DIV_MAX_N  = 8'(CE_DIV - 1);
  localparam logic [7:0] DIV_MAX_SD = 8'(CE_DIV / 2 - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Galois LFSR, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic       pal_q, pal_d, sd_q, sd_d;
  pattern_e   pat_q, pat_d;
  logic [7:0] div_q, div_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [15:0] frame_q, frame_d, lfsr_q, lfsr_d;
  logic       ce_q, ce_d, fs_q, fs_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] video_q, video_d;
  logic [7:0] div_max, div_max_nxt;
  logic [9:0] vt_last;
  logic       adv;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    div_max  = sd_q ? DIV_MAX_SD : DIV_MAX_N;
    adv      = (div_q == div_max);
    vt_last  = ((pal_q ? VT_PAL : VT_NTSC) << sd_q) - 10'd1;
    div_d    = div_q + 8'd1;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    frame_d  = frame_q;
    lfsr_d   = lfsr_q;
    pal_d    = pal_q;
    sd_d     = sd_q;
    pat_d    = pat_q;
    fs_d     = 1'b0;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    x_d      = x_q;
    y_d      = y_q;
    video_d  = video_q;

    if (adv) begin
      div_d = '0;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == vt_last) begin
          // Frame boundary: modes for the whole next frame are captured here.
          vcnt_d  = '0;
          frame_d = frame_q + 16'd1;
          fs_d    = 1'b1;
          pal_d   = vid.pal;
          sd_d    = vid.scandouble;
          pat_d   = pattern_e'(vid.pattern);
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      hblank_d = (hcnt_d >= H_ACT);
      hsync_d  = (hcnt_d >= HS_BEG) && (hcnt_d < HS_END);
      vblank_d = (vcnt_d >= (V_ACT << sd_d));
      vsync_d  = (vcnt_d >= (VS_BEG << sd_d)) && (vcnt_d < (VS_END << sd_d));
      x_d      = hcnt_d;
      y_d      = vcnt_d >> sd_d;

      if (hblank_d || vblank_d) begin
        video_d = '0;
      end else begin
        case (pat_d)
          PAT_NOISE: begin
            lfsr_d  = lfsr_step(lfsr_q);
            video_d = lfsr_d[7:0];
          end
          PAT_GRADIENT: video_d = hcnt_d[7:0];
          PAT_CHECKER:  video_d = (hcnt_d[3] ^ y_d[3]) ? 8'hFF : 8'h00;
          PAT_SCROLL:   video_d = hcnt_d[7:0] + frame_d[7:0];
          default:      video_d = '0;
        endcase
      end
    end

    div_max_nxt = sd_d ? DIV_MAX_SD : DIV_MAX_N;
    ce_d        = (div_d == div_max_nxt);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      pal_q    <= vid.pal;
      sd_q     <= vid.scandouble;
      pat_q    <= pattern_e'(vid.pattern);
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      frame_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      ce_q     <= 1'b0;
      fs_q     <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      video_q  <= '0;
    end else begin
      pal_q    <= pal_d;
      sd_q     <= sd_d;
      pat_q    <= pat_d;
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      frame_q  <= frame_d;
      lfsr_q   <= lfsr_d;
      ce_q     <= ce_d;
      fs_q     <= fs_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      x_q      <= x_d;
      y_q      <= y_d;
      video_q  <= video_d;
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.frame_start = fs_q;
  assign vid.HBlank      = hblank_q;
  assign vid.VBlank      = vblank_q;
  assign vid.HSync       = hsync_q;
  assign vid.VSync       = vsync_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame       = frame_q;
  assign vid.video       = video_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a shrunken raster: a clock-count model checked every
// cycle, plus directed checks of reset, ce spacing, frame periods and pattern switching.
module tb_video_timing_gen;

  localparam int CE_DIV   = 4;
  localparam int H_ACTIVE = 20;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 10;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_NTSC   = 16;
  localparam int V_PAL    = 20;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  logic clk;
  logic reset_n;
  video_timing_gen_if vif ();

  video_timing_gen #(
    .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .V_TOTAL_NTSC(V_NTSC), .V_TOTAL_PAL(V_PAL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vid(vif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      if (bad >= 200) finish_run();
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Reference model: position derived from clocks elapsed in the frame.
  function automatic logic [15:0] galois(input logic [15:0] s);
    galois = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  int          m_c;
  bit          m_pal, m_sd, model_ok = 0;
  logic [1:0]  m_pat;
  logic [15:0] m_frame, m_lfsr;
  logic        e_ce, e_fs, e_hb, e_vb, e_hs, e_vs;
  logic [9:0]  e_x, e_y;
  logic [7:0]  e_video;

  always @(posedge clk) begin : model
    int div, p, h, v, line, vt;
    if (!reset_n) begin
      m_c = 0; m_frame = 0; m_lfsr = 16'hACE1;
      m_pal = vif.pal; m_sd = vif.scandouble; m_pat = vif.pattern;
      e_ce = 0; e_fs = 0; e_hb = 0; e_vb = 0; e_hs = 0; e_vs = 0;
      e_x = 0; e_y = 0; e_video = 0;
      model_ok = 1;
    end else begin
      div = CE_DIV >> m_sd;
      m_c++;
      e_fs = 0;
      if (m_c % div == 0) begin
        p  = m_c / div;
        vt = (m_pal ? V_PAL : V_NTSC) << m_sd;
        if (p == H_TOTAL * vt) begin
          p = 0; m_c = 0; m_frame++; e_fs = 1;
          m_pal = vif.pal; m_sd = vif.scandouble; m_pat = vif.pattern;
        end
        h = p % H_TOTAL;
        v = p / H_TOTAL;
        line = v >> m_sd;
        e_x  = 10'(h);
        e_y  = 10'(line);
        e_hb = (h >= H_ACTIVE);
        e_hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        e_vb = (line >= V_ACTIVE);
        e_vs = (line >= V_ACTIVE + V_FP) && (line < V_ACTIVE + V_FP + V_SYNC);
        if (e_hb || e_vb) e_video = 0;
        else begin
          case (m_pat)
            2'd0: begin m_lfsr = galois(m_lfsr); e_video = m_lfsr[7:0]; end
            2'd1: e_video = 8'(h);
            2'd2: e_video = (((h >> 3) & 1) != ((line >> 3) & 1)) ? 8'hFF : 8'h00;
            default: e_video = 8'((h + int'(m_frame)) % 256);
          endcase
        end
      end
      e_ce = ((m_c + 1) % (CE_DIV >> m_sd)) == 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("ce_pix", vif.ce_pix, e_ce);
      check("frame_start", vif.frame_start, e_fs);
      check("HBlank", vif.HBlank, e_hb);
      check("VBlank", vif.VBlank, e_vb);
      check("HSync", vif.HSync, e_hs);
      check("VSync", vif.VSync, e_vs);
      check("x", vif.x, e_x);
      check("y", vif.y, e_y);
      check("frame", vif.frame, m_frame);
      check("video", vif.video, e_video);
    end
  end

  task automatic wait_fs(input string name, output int stamp);
    int k = 0;
    do begin @(negedge clk); k++; end while (!vif.frame_start && k < 3000);
    if (!vif.frame_start) timeout(name);
    stamp = cyc;
  endtask

  task automatic wait_ce(input string name, output int stamp);
    int k = 0;
    do begin @(negedge clk); k++; end while (!vif.ce_pix && k < 64);
    if (!vif.ce_pix) timeout(name);
    stamp = cyc;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {vif.ce_pix, vif.frame_start, vif.HBlank, vif.VBlank, vif.HSync, vif.VSync}, 0);
    check({name, "_xy"}, {vif.x, vif.y}, 0);
    check({name, "_frame"}, vif.frame, 0);
    check({name, "_video"}, vif.video, 0);
  endtask

  initial begin
    int k, t0, t1, t2, t3, t4, t5, t6, a, b;
    reset_n = 1'b0;
    vif.pal = 1'b0; vif.scandouble = 1'b0; vif.pattern = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // First ce_pix lands in the CE_DIV-th clock after release.
    k = 1;
    while (!vif.ce_pix && k < 50) begin @(negedge clk); k++; end
    check("first_ce_clk", k, CE_DIV);
    @(negedge clk);
    check("first_x", vif.x, 1);
    check("first_noise", vif.video, 8'h70);

    wait_fs("fs0", t0);
    check("frame_after_fs0", vif.frame, 1);
    wait_fs("fs1", t1);
    check("ntsc_period", t1 - t0, H_TOTAL * V_NTSC * CE_DIV);

    // Mid-frame mode change must not affect the running frame.
    repeat (500) @(negedge clk);
    vif.pal = 1'b1; vif.pattern = 2'd1;
    wait_fs("fs2", t2);
    check("pal_toggle_old_period", t2 - t1, H_TOTAL * V_NTSC * CE_DIV);
    check("gradient_at_origin", vif.video, 0);
    repeat (5) wait_ce("ce_grad", a);
    @(negedge clk);
    check("gradient_x", vif.x, 5);
    check("gradient_video", vif.video, 5);
    wait_fs("fs3", t3);
    check("pal_period", t3 - t2, H_TOTAL * V_PAL * CE_DIV);

    vif.pal = 1'b0; vif.scandouble = 1'b1; vif.pattern = 2'd2;
    wait_fs("fs4", t4);
    check("pal_period_again", t4 - t3, H_TOTAL * V_PAL * CE_DIV);
    wait_ce("ce_sd_a", a);
    wait_ce("ce_sd_b", b);
    check("sd_ce_spacing", b - a, CE_DIV / 2);
    wait_fs("fs5", t5);
    check("sd_period", t5 - t4, H_TOTAL * V_NTSC * 2 * (CE_DIV / 2));

    vif.scandouble = 1'b0; vif.pattern = 2'd3;
    wait_fs("fs6", t6);
    check("sd_period_again", t6 - t5, H_TOTAL * V_NTSC * CE_DIV);
    check("frame_count", vif.frame, 7);
    repeat (5) wait_ce("ce_scroll", a);
    @(negedge clk);
    check("scroll_video", vif.video, 8'd12);

    // One-clock reset pulse mid-line: everything restarts, LFSR reseeded.
    repeat (37) @(negedge clk);
    vif.pattern = 2'd0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("midreset");
    k = 1;
    while (!vif.ce_pix && k < 50) begin @(negedge clk); k++; end
    check("midreset_first_ce", k, CE_DIV);
    @(negedge clk);
    check("midreset_noise", vif.video, 8'h70);

    wait_fs("fs7", t0);
    wait_fs("fs8", t1);
    check("final_period", t1 - t0, H_TOTAL * V_NTSC * CE_DIV);
    finish_run();
  end

endmodule
